dsp_mac_sequencer: RTL

Sequences one `DSPELogic` multiply-accumulate element through a complete dot product of configurable length. It accepts operand pairs on a valid/ready stream and drives the DSP flow-control inputs (`bypass_mlt`, `bypass_add`, `reset_acc`). It tracks vector completion through the DSP's extra-signal pipe and presents the finished accumulator on a one-deep valid/ready result port. It sits between the KAN layer operand fetch and the result write-back, one instance per DSP element.

---
 rtl/dsp_mac_sequencer_if.sv | 24 ++
 rtl/dsp_mac_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream (s_*) and one-deep result port (m_*) of dsp_mac_sequencer.
interface dsp_mac_sequencer_if #(
  parameter int OP0_SIZE = 8,
  parameter int OP1_SIZE = 8,
  parameter int ACC_SIZE = 8
);
  logic                s_valid;
  logic                s_ready;
  logic [OP0_SIZE-1:0] s_op0;
  logic [OP1_SIZE-1:0] s_op1;
  logic                m_valid;
  logic                m_ready;
  logic [ACC_SIZE-1:0] m_acc;

  modport master (
    output s_valid, s_op0, s_op1, m_ready,
    input  s_ready, m_valid, m_acc
  );

  modport slave (
    input  s_valid, s_op0, s_op1, m_ready,
    output s_ready, m_valid, m_acc
  );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSPELogic MAC element through a dot product of cfg_len products.
// Define DSP_SEQ_BIAS_EN to preload the accumulator with cfg_bias before the first product.
module dsp_mac_sequencer #(
  parameter int OP0_SIZE       = 8,
  parameter int OP1_SIZE       = 8,
  parameter int ACC_SIZE       = 8,
  parameter int PIPELINE_LEVEL = 0,
  parameter int LEN_SIZE       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_SIZE-1:0] cfg_len,
  input  logic [ACC_SIZE-1:0] cfg_bias,
  output logic                busy,
  dsp_mac_sequencer_if.slave  bus,
  output logic [OP0_SIZE-1:0] dsp_op0,
  output logic [OP1_SIZE-1:0] dsp_op1,
  output logic [ACC_SIZE-1:0] dsp_op2,
  output logic                dsp_bypass_mlt,
  output logic                dsp_bypass_add,
  output logic                dsp_reset_acc,
  output logic                dsp_extra_in,
  input  logic                dsp_extra_out,
  input  logic [ACC_SIZE-1:0] dsp_acc
);

  // Completion is tracked through the DSP's extra pipe, so latency needs no local knowledge.
  localparam int unsigned UNUSED_PIPELINE_LEVEL = PIPELINE_LEVEL;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    RUN,
    DRAIN,
    OUT
  } state_t;

  state_t              state, state_nx;
  logic [LEN_SIZE-1:0] cnt, cnt_nx;
  logic                first, first_nx;
  logic                tag_seen;

`ifdef DSP_SEQ_BIAS_EN
  logic [ACC_SIZE-1:0] bias_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_q <= '0;
    end else if (state == IDLE && start) begin
      bias_q <= cfg_bias;
    end
  end
`else
  logic unused_cfg_bias;
  assign unused_cfg_bias = ^cfg_bias;
`endif

  assign busy     = (state != IDLE);
  assign tag_seen = (state == DRAIN) && dsp_extra_out;

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    first_nx       = first;
    bus.s_ready    = 1'b0;
    dsp_op0        = '0;
    dsp_op1        = '0;
    dsp_op2        = '0;
    dsp_bypass_mlt = 1'b0;
    dsp_bypass_add = 1'b1;
    dsp_reset_acc  = 1'b0;
    dsp_extra_in   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = cfg_len;
          first_nx = 1'b1;
`ifdef DSP_SEQ_BIAS_EN
          state_nx = BIAS;
`else
          state_nx = RUN;
`endif
        end
      end

      BIAS: begin
`ifdef DSP_SEQ_BIAS_EN
        // Load bias as the "product" into a freshly reset accumulator.
        dsp_bypass_mlt = 1'b1;
        dsp_bypass_add = 1'b0;
        dsp_reset_acc  = 1'b1;
        dsp_op2        = bias_q;
        first_nx       = 1'b0;
        if (cnt == '0) begin
          dsp_extra_in = 1'b1;
          state_nx     = DRAIN;
        end else begin
          state_nx = RUN;
        end
`else
        state_nx = IDLE;
`endif
      end

      RUN: begin
        if (cnt == '0) begin
          // Empty vector: clear the accumulator and tag it in one command.
          dsp_bypass_add = 1'b1;
          dsp_reset_acc  = 1'b1;
          dsp_extra_in   = 1'b1;
          state_nx       = DRAIN;
        end else begin
          bus.s_ready = 1'b1;
          if (bus.s_valid) begin
            dsp_op0        = bus.s_op0;
            dsp_op1        = bus.s_op1;
            dsp_bypass_add = 1'b0;
            dsp_reset_acc  = first;
            first_nx       = 1'b0;
            cnt_nx         = cnt - 1'b1;
            if (cnt == LEN_SIZE'(1)) begin
              dsp_extra_in = 1'b1;
              state_nx     = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (tag_seen) begin
          state_nx = OUT;
        end
      end

      OUT: begin
        if (bus.m_ready) begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      first       <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_acc   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      first <= first_nx;
      if (tag_seen) begin
        bus.m_acc   <= dsp_acc;
        bus.m_valid <= 1'b1;
      end else if (state == OUT && bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

endmodule
